clock_set_controller: RTL and testbench

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

---
 rtl/clock_set_controller.sv | 177 +++++++++++++++++
 tb/tb_clock_set_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - button-driven BCD time-set controller for a 24-hour clock
//
// Purpose:
//   Walks the user through hours, minutes and seconds with a Mode button,
//   bumps the selected BCD field with an Inc button, then issues a single
//   load strobe carrying the edited time to the 24-hour clock.
//
// Optional feature (macro CLKSET_TIMEOUT_EN):
//   When defined, an edit that sees no button event for TIMEOUT_CYCLES cycles
//   is abandoned and the controller returns to RUN without loading.
//   When undefined, edit states are held indefinitely.
//
// Ports:
//   CLK        in   1   system clock, rising edge
//   Reset_n    in   1   asynchronous active-low reset
//   Mode_btn   in   1   level; rising edge advances the edit sequence
//   Inc_btn    in   1   level; rising edge increments the field under edit
//   Time_cur   in   24  current time, BCD {HH,MM,SS}
//   Set_time   out  1   one-cycle load strobe
//   Time_in    out  24  time to load, BCD {HH,MM,SS} (shadow register)
//   Editing    out  1   high whenever not in RUN
//   Edit_field out  2   00 none, 01 hours, 10 minutes, 11 seconds

module clock_set_controller #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Mode_btn,
  input  logic        Inc_btn,
  input  logic [23:0] Time_cur,
  output logic        Set_time,
  output logic [23:0] Time_in,
  output logic        Editing,
  output logic [1:0]  Edit_field
);

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_HR     = 3'd1;
  localparam logic [2:0] S_MIN    = 3'd2;
  localparam logic [2:0] S_SEC    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [23:0] shadow;
  logic [23:0] shadow_nxt;
  logic        mode_q;
  logic        inc_q;
  logic        armed;
  logic        mode_ev;
  logic        inc_ev;
  logic        in_edit;
  logic        timed_out;

  // Increment a two-digit BCD value, wrapping at 'top' back to 00. The ones
  // digit carries into the tens digit of the same field only.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // 'armed' stays low for the first clock after reset so that a button held
  // through reset release is sampled into its edge register without firing.
  assign mode_ev = armed & Mode_btn & ~mode_q;
  // Mode wins over a simultaneous Inc.
  assign inc_ev  = armed & Inc_btn & ~inc_q & ~mode_ev;
  assign in_edit = (state == S_HR) || (state == S_MIN) || (state == S_SEC);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      mode_q <= Mode_btn;
      inc_q  <= Inc_btn;
      armed  <= 1'b1;
    end
  end

`ifdef CLKSET_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_cnt;

  // Entry into any edit state always comes from a Mode event, so clearing on
  // events also covers the clear-on-entry case.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)
      idle_cnt <= '0;
    else if (!in_edit || mode_ev || inc_ev)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timed_out = in_edit && (idle_cnt == CNT_LAST) && !mode_ev && !inc_ev;
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    case (state)
      S_RUN: begin
        if (mode_ev) begin
          state_nxt  = S_HR;
          shadow_nxt = Time_cur;
        end
      end
      S_HR: begin
        if (mode_ev)
          state_nxt = S_MIN;
        else if (inc_ev)
          shadow_nxt[23:16] = bcd_inc(shadow[23:16], 8'h23);
      end
      S_MIN: begin
        if (mode_ev)
          state_nxt = S_SEC;
        else if (inc_ev)
          shadow_nxt[15:8] = bcd_inc(shadow[15:8], 8'h59);
      end
      S_SEC: begin
        if (mode_ev)
          state_nxt = S_COMMIT;
        else if (inc_ev)
          shadow_nxt[7:0] = bcd_inc(shadow[7:0], 8'h59);
      end
      S_COMMIT: begin
        // Button events are ignored here; the strobe is exactly one cycle.
        state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
    // Abandon the edit: no commit, shadow left as-is (it is never loaded).
    if (timed_out) begin
      state_nxt  = S_RUN;
      shadow_nxt = shadow;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_RUN;
      shadow <= 24'h000000;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
    end
  end

  assign Set_time = (state == S_COMMIT);
  assign Time_in  = shadow;
  assign Editing  = (state != S_RUN);

  always_comb begin
    Edit_field = 2'b00;
    case (state)
      S_HR:    Edit_field = 2'b01;
      S_MIN:   Edit_field = 2'b10;
      S_SEC:   Edit_field = 2'b11;
      default: Edit_field = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed table-driven bench for clock_set_controller

module tb_clock_set_controller;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Mode_btn = 1'b0;
  logic        Inc_btn = 1'b0;
  logic [23:0] Time_cur = 24'h000000;
  logic        Set_time;
  logic [23:0] Time_in;
  logic        Editing;
  logic [1:0]  Edit_field;

  clock_set_controller #(.TIMEOUT_CYCLES(8)) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .Mode_btn   (Mode_btn),
    .Inc_btn    (Inc_btn),
    .Time_cur   (Time_cur),
    .Set_time   (Set_time),
    .Time_in    (Time_in),
    .Editing    (Editing),
    .Edit_field (Edit_field)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  always @(negedge CLK) if (Set_time === 1'b1) pulses++;

  typedef struct {
    logic        m;
    logic        i;
    logic [23:0] tc;
    logic        set;
    logic [23:0] tin;
    logic        ed;
    logic [1:0]  f;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic m, input logic i, input logic [23:0] tc,
                     input logic set, input logic [23:0] tin, input logic ed,
                     input logic [1:0] f);
    vec_t v;
    v.m = m; v.i = i; v.tc = tc; v.set = set; v.tin = tin; v.ed = ed; v.f = f;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic i);
    @(negedge CLK);
    Mode_btn = m;
    Inc_btn  = i;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " set"},   {31'd0, Set_time}, 32'd0);
    chk({tag, " tin"},   {8'd0, Time_in},   32'd0);
    chk({tag, " ed"},    {31'd0, Editing},  32'd0);
    chk({tag, " field"}, {30'd0, Edit_field}, 32'd0);
  endtask

  task automatic do_reset(input logic hold_mode);
    @(negedge CLK);
    Reset_n  = 1'b0;
    Mode_btn = hold_mode;
    Inc_btn  = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  initial begin
    int p0;

    // Reset state, with a non-zero Time_cur that must not leak into the shadow.
    Time_cur = 24'h123456;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset_held");
    Reset_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_reset_outputs("post_release");

    // Main sequences: plain commit with single incs, full-field wrap, Mode+Inc together.
    add(1, 0, 24'h123456, 0, 24'h123456, 1, 2'b01);
    add(0, 1, 24'h123456, 0, 24'h133456, 1, 2'b01);
    add(0, 0, 24'h123456, 0, 24'h133456, 1, 2'b01);
    add(1, 0, 24'h123456, 0, 24'h133456, 1, 2'b10);
    add(0, 1, 24'h123456, 0, 24'h133556, 1, 2'b10);
    add(0, 0, 24'h123456, 0, 24'h133556, 1, 2'b10);
    add(1, 0, 24'h123456, 0, 24'h133556, 1, 2'b11);
    add(0, 1, 24'h123456, 0, 24'h133557, 1, 2'b11);
    add(0, 0, 24'h123456, 0, 24'h133557, 1, 2'b11);
    add(1, 0, 24'h123456, 1, 24'h133557, 1, 2'b00);
    add(0, 0, 24'h123456, 0, 24'h133557, 0, 2'b00);
    add(0, 1, 24'h123456, 0, 24'h133557, 0, 2'b00);
    add(0, 0, 24'h235959, 0, 24'h133557, 0, 2'b00);
    add(1, 0, 24'h235959, 0, 24'h235959, 1, 2'b01);
    add(0, 1, 24'h235959, 0, 24'h005959, 1, 2'b01);
    add(0, 0, 24'h235959, 0, 24'h005959, 1, 2'b01);
    add(1, 0, 24'h235959, 0, 24'h005959, 1, 2'b10);
    add(0, 1, 24'h235959, 0, 24'h000059, 1, 2'b10);
    add(0, 0, 24'h235959, 0, 24'h000059, 1, 2'b10);
    add(1, 0, 24'h235959, 0, 24'h000059, 1, 2'b11);
    add(0, 1, 24'h235959, 0, 24'h000000, 1, 2'b11);
    add(0, 0, 24'h235959, 0, 24'h000000, 1, 2'b11);
    add(1, 0, 24'h235959, 1, 24'h000000, 1, 2'b00);
    add(0, 0, 24'h235959, 0, 24'h000000, 0, 2'b00);
    add(1, 0, 24'h083000, 0, 24'h083000, 1, 2'b01);
    add(0, 0, 24'h083000, 0, 24'h083000, 1, 2'b01);
    add(1, 0, 24'h083000, 0, 24'h083000, 1, 2'b10);
    add(0, 0, 24'h083000, 0, 24'h083000, 1, 2'b10);
    add(1, 1, 24'h083000, 0, 24'h083000, 1, 2'b11);
    add(0, 0, 24'h083000, 0, 24'h083000, 1, 2'b11);
    add(0, 1, 24'h083000, 0, 24'h083001, 1, 2'b11);
    add(0, 0, 24'h083000, 0, 24'h083001, 1, 2'b11);
    add(1, 0, 24'h083000, 1, 24'h083001, 1, 2'b00);
    add(0, 0, 24'h083000, 0, 24'h083001, 0, 2'b00);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge CLK);
      Time_cur = vq[k].tc;
      Mode_btn = vq[k].m;
      Inc_btn  = vq[k].i;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d set", k),   {31'd0, Set_time},   {31'd0, vq[k].set});
      chk($sformatf("v%0d tin", k),   {8'd0, Time_in},     {8'd0, vq[k].tin});
      chk($sformatf("v%0d ed", k),    {31'd0, Editing},    {31'd0, vq[k].ed});
      chk($sformatf("v%0d field", k), {30'd0, Edit_field}, {30'd0, vq[k].f});
    end
    step(1'b0, 1'b0);
    chk("table_pulses", pulses, 3);

    // Inc held for 50 cycles counts once; ones digit 9 carries into tens.
    Time_cur = 24'h090909;
    step(1'b1, 1'b0);
    for (int c = 0; c < 50; c++) step(1'b0, 1'b1);
    chk("held_inc tin", {8'd0, Time_in}, {8'd0, 24'h100909});
    chk("held_inc field", {30'd0, Edit_field}, 32'd1);
    step(1'b0, 1'b0);

    // Reset in EDIT_SEC: abort without a strobe.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("pre_abort field", {30'd0, Edit_field}, 32'd3);
    p0 = pulses;
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    repeat (3) @(negedge CLK);
    check_reset_outputs("abort_held");
    Mode_btn = 1'b0;
    Reset_n  = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0);
    check_reset_outputs("abort_after");
    chk("abort_pulses", pulses, p0);

    // Mode held through reset release must not start an edit.
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
    chk("held_mode ed", {31'd0, Editing}, 32'd0);
    step(1'b0, 1'b0);
    Time_cur = 24'h111111;
    step(1'b1, 1'b0);
    chk("repress ed", {31'd0, Editing}, 32'd1);
    chk("repress field", {30'd0, Edit_field}, 32'd1);
    chk("repress tin", {8'd0, Time_in}, {8'd0, 24'h111111});

    // Idle behaviour in an edit state.
    do_reset(1'b0);
    step(1'b0, 1'b0);
    p0 = pulses;
    step(1'b1, 1'b0);
`ifdef CLKSET_TIMEOUT_EN
    for (int c = 0; c < 7; c++) step(1'b0, 1'b0);
    chk("to_7 ed", {31'd0, Editing}, 32'd1);
    step(1'b0, 1'b0);
    chk("to_8 ed", {31'd0, Editing}, 32'd0);
    chk("to_8 field", {30'd0, Edit_field}, 32'd0);
    chk("to_pulses", pulses, p0);
    step(1'b1, 1'b0);
    for (int c = 0; c < 7; c++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("to_mode_prio field", {30'd0, Edit_field}, 32'd2);
`else
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0);
    chk("no_to ed", {31'd0, Editing}, 32'd1);
    chk("no_to field", {30'd0, Edit_field}, 32'd1);
    chk("no_to pulses", pulses, p0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
